// File: rtl/chip_modulator_if.sv
// rtl/chip_modulator_if.sv - symbol handshake and phase/flag output bundle for chip_modulator
// Signals:
//   i_sym[3:0], i_valid, i_last, o_ready : symbol transfer from the frame/symbol source
//   o_phase, o_flag                      : MSK phase direction and its sample strobe
//   o_busy, o_done, o_underrun           : burst status
// Modports: master = source/sink side, slave = modulator.
interface chip_modulator_if;
  logic [3:0] i_sym;
  logic       i_valid;
  logic       i_last;
  logic       o_ready;
  logic       o_phase;
  logic       o_flag;
  logic       o_busy;
  logic       o_done;
  logic       o_underrun;

  modport master (
    output i_sym, i_valid, i_last,
    input  o_ready, o_phase, o_flag, o_busy, o_done, o_underrun
  );

  modport slave (
    input  i_sym, i_valid, i_last,
    output o_ready, o_phase, o_flag, o_busy, o_done, o_underrun
  );
endinterface

// File: rtl/chip_modulator.sv
// rtl/chip_modulator.sv - 802.15.4 DSSS spreader and MSK phase/flag generator
// Ports:
//   i_clk  : system clock
//   i_rst  : synchronous reset, active-high
//   bus    : chip_modulator_if.slave (symbol handshake in, phase/flag/status out)
// Parameters:
//   CLK_DIV : clock cycles between o_flag pulses (>=2)
//   OSR     : o_flag samples per chip (>=1)
module chip_modulator #(
  parameter int CLK_DIV = 4,
  parameter int OSR     = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  chip_modulator_if.slave bus
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SAMP_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OSR - 1);

  // Symbol 0 chip sequence, MSB = chip 0.
  localparam logic [31:0] SYM0_CHIPS = 32'b1101_1001_1100_0011_0101_0010_0010_1110;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_END} state_t;

  state_t state_q, state_d;

  logic [3:0]        act_sym, hold_sym;
  logic              act_last, hold_last, hold_full;
  logic [DIV_W-1:0]  div_q;
  logic [SAMP_W-1:0] samp_q;
  logic [4:0]        chip_q;
  logic              c_prev;
  logic              underrun_q;

  logic [4:0] chip_idx;
  logic       chip_bit;
  logic       sample_end, chip_end;
  logic       sym_end_load, idle_load, load;
  logic       ready, accept;
  logic       flag, phase, busy, done;

  // Rotating right by 4k chips means chip n of symbol k is chip n-4k of symbol 0;
  // symbols 8..15 additionally invert the odd chips.
  assign chip_idx = chip_q - {act_sym[2:0], 2'b00};
  assign chip_bit = SYM0_CHIPS[~chip_idx] ^ (act_sym[3] & chip_q[0]);

  assign sample_end   = (state_q == ST_SEND) && (div_q == DIV_LAST) && (samp_q == SAMP_LAST);
  assign chip_end     = sample_end && (chip_q == 5'd31);
  assign sym_end_load = chip_end && !act_last && hold_full;
  assign idle_load    = (state_q == ST_IDLE) && hold_full;
  assign load         = sym_end_load || idle_load;

  // The holding slot counts as free on the cycle it drains, so the source can
  // refill it without a bubble. Depends on registered state only.
  assign ready  = !hold_full || load;
  assign accept = bus.i_valid && ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    flag    = 1'b0;
    phase   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hold_full || accept) state_d = ST_SEND;
      end
      ST_SEND: begin
        busy  = 1'b1;
        flag  = (div_q == '0);
        // Constant for a whole chip period, so it only changes on the chip's first flag.
        phase = chip_bit ^ c_prev ^ chip_q[0];
        if (chip_end) begin
          if (act_last)        state_d = ST_END;
          else if (!hold_full) state_d = ST_IDLE;
        end
      end
      ST_END: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      act_sym    <= '0;
      act_last   <= 1'b0;
      hold_sym   <= '0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      div_q      <= '0;
      samp_q     <= '0;
      chip_q     <= '0;
      c_prev     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= chip_end && !act_last && !hold_full;

      if (load) begin
        act_sym   <= hold_sym;
        act_last  <= hold_last;
        hold_full <= 1'b0;
      end else if (accept && (state_q == ST_IDLE)) begin
        act_sym  <= bus.i_sym;
        act_last <= bus.i_last;
      end

      // Only an idle modulator with an empty slot bypasses the holding register.
      if (accept && !((state_q == ST_IDLE) && !hold_full)) begin
        hold_sym  <= bus.i_sym;
        hold_last <= bus.i_last;
        hold_full <= 1'b1;
      end

      if (state_q == ST_SEND) begin
        div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        if (div_q == DIV_LAST) begin
          samp_q <= (samp_q == SAMP_LAST) ? '0 : samp_q + SAMP_W'(1);
          if (samp_q == SAMP_LAST) begin
            chip_q <= chip_q + 5'd1;
            c_prev <= chip_bit;
          end
        end
      end else begin
        div_q  <= '0;
        samp_q <= '0;
        chip_q <= '0;
        c_prev <= 1'b0;
      end
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_flag     = flag;
  assign bus.o_phase    = phase;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign bus.o_underrun = underrun_q;

endmodule
